fetch_unit: RTL and testbench

//  Parametrised front end: owns PC/order counters, a one-line instruction buffer and a flushable

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_iq.sv | 62 ++++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front end: FSM states and the queue entry layout.
package fetch_unit_pkg;

  localparam int ORDER_W_DEF = 64;

  typedef enum logic {
    FETCH_RUN,
    FETCH_MISS
  } fetch_state_t;

  typedef struct packed {
    logic [ORDER_W_DEF-1:0] order;
    logic [31:0]            pc;
    logic [31:0]            inst;
  } iq_entry_t;

endpackage

// File: rtl/fetch_iq.sv
// Flushable circular instruction queue; head entry is read combinationally, no fall-through.
module fetch_iq
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = $bits(iq_entry_t)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enq,
  input  logic [DATA_W-1:0]      i_enq_data,
  input  logic                   i_deq,
  input  logic                   i_flush,
  output logic [DATA_W-1:0]      o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [PW:0]       r_count;
  logic              w_enq;
  logic              w_deq;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

  // Fullness is judged on the count at cycle start, so a same-cycle dequeue never frees a slot.
  assign w_enq = i_enq && !o_full && !i_flush;
  assign w_deq = i_deq && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= i_enq_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(1);
      if (w_deq) r_head <= r_head + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC/order counters, one-line buffer filled from the I-cache, and a
// flushable queue feeding decode; redirect restarts fetch without cancelling a pending miss.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'haaaaa000,
  parameter int          LINE_BYTES = 32,
  parameter int          IQ_DEPTH   = 16,
  parameter int          ORDER_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_redirect_valid,
  input  logic [31:0]                 i_redirect_pc,
  input  logic [ORDER_W-1:0]          i_redirect_order,
  output logic [31:0]                 o_ic_addr,
  output logic [3:0]                  o_ic_rmask,
  input  logic [LINE_BYTES*8-1:0]     i_ic_rline,
  input  logic                        i_ic_resp,
  output logic                        o_deq_valid,
  input  logic                        i_deq_ready,
  output logic [31:0]                 o_deq_inst,
  output logic [31:0]                 o_deq_pc,
  output logic [ORDER_W-1:0]          o_deq_order,
  output logic [$clog2(IQ_DEPTH):0]   o_iq_count
);

  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int TAG_W  = 32 - OFF;
  localparam int ENT_W  = ORDER_W + 64;

  fetch_state_t            r_state, w_state_next;
  logic [31:0]             r_pc, w_pc_next;
  logic [ORDER_W-1:0]      r_order, w_order_next;
  logic                    r_lb_valid, w_lb_valid_next;
  logic [TAG_W-1:0]        r_lb_tag, w_lb_tag_next;
  logic [LINE_BYTES*8-1:0] r_lb_data, w_lb_data_next;
  logic [TAG_W-1:0]        r_req_tag, w_req_tag_next;
  logic [31:0]             r_ic_addr, w_ic_addr_next;
  logic [3:0]              r_ic_rmask, w_ic_rmask_next;

  logic [31:0]             w_words [WORDS];
  logic [31:0]             w_inst;
  logic                    w_hit;
  logic                    w_enq;
  logic                    w_deq;
  logic                    w_full;
  logic                    w_empty;
  logic [ENT_W-1:0]        w_head;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign w_words[gi] = r_lb_data[gi*32 +: 32];
    end
  endgenerate

  assign w_hit  = r_lb_valid && (r_pc[31:OFF] == r_lb_tag);
  assign w_inst = w_words[r_pc[OFF-1:2]];

  assign o_ic_addr   = r_ic_addr;
  assign o_ic_rmask  = r_ic_rmask;
  assign o_deq_valid = !w_empty && !i_redirect_valid;
  assign w_deq       = o_deq_valid && i_deq_ready;
  assign o_deq_order = w_head[ENT_W-1:64];
  assign o_deq_pc    = w_head[63:32];
  assign o_deq_inst  = w_head[31:0];

  fetch_iq #(
    .DEPTH  (IQ_DEPTH),
    .DATA_W (ENT_W)
  ) u_iq (
    .clk        (clk),
    .rst        (rst),
    .i_enq      (w_enq),
    .i_enq_data ({r_order, r_pc, w_inst}),
    .i_deq      (w_deq),
    .i_flush    (i_redirect_valid),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (o_iq_count)
  );

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_order_next    = r_order;
    w_lb_valid_next = r_lb_valid;
    w_lb_tag_next   = r_lb_tag;
    w_lb_data_next  = r_lb_data;
    w_req_tag_next  = r_req_tag;
    w_ic_addr_next  = r_ic_addr;
    w_ic_rmask_next = r_ic_rmask;
    w_enq           = 1'b0;

    case (r_state)
      FETCH_RUN: begin
        if (!i_redirect_valid) begin
          if (w_hit) begin
            if (!w_full) begin
              w_enq        = 1'b1;
              w_pc_next    = r_pc + 32'd4;
              w_order_next = r_order + ORDER_W'(1);
            end
          end else begin
            w_req_tag_next  = r_pc[31:OFF];
            w_ic_addr_next  = {r_pc[31:OFF], {OFF{1'b0}}};
            w_ic_rmask_next = 4'hF;
            w_state_next    = FETCH_MISS;
          end
        end
      end
      FETCH_MISS: begin
        // A redirect does not cancel the miss: the line still lands under the requested tag.
        if (i_ic_resp) begin
          w_lb_tag_next   = r_req_tag;
          w_lb_data_next  = i_ic_rline;
          w_lb_valid_next = 1'b1;
          w_ic_rmask_next = 4'h0;
          w_state_next    = FETCH_RUN;
        end
      end
      default: w_state_next = FETCH_RUN;
    endcase

    if (i_redirect_valid) begin
      w_pc_next    = {i_redirect_pc[31:2], 2'b00};
      w_order_next = i_redirect_order;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH_RUN;
      r_pc       <= RESET_PC;
      r_order    <= '0;
      r_lb_valid <= 1'b0;
      r_lb_tag   <= '0;
      r_lb_data  <= '0;
      r_req_tag  <= '0;
      r_ic_addr  <= '0;
      r_ic_rmask <= 4'h0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_order    <= w_order_next;
      r_lb_valid <= w_lb_valid_next;
      r_lb_tag   <= w_lb_tag_next;
      r_lb_data  <= w_lb_data_next;
      r_req_tag  <= w_req_tag_next;
      r_ic_addr  <= w_ic_addr_next;
      r_ic_rmask <= w_ic_rmask_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random-latency cache responder, directed scenarios, and a
// sequence model (next expected pc/order per dequeue, reset by redirect) checked every cycle.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'haaaaa000;
  localparam int LINE_BYTES = 32;
  localparam int IQ_DEPTH   = 16;
  localparam int ORDER_W    = 64;

  logic               clk;
  logic               rst;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic [63:0]        redirect_order;
  logic [31:0]        ic_addr;
  logic [3:0]         ic_rmask;
  logic [255:0]       ic_rline;
  logic               ic_resp;
  logic               deq_valid;
  logic               deq_ready;
  logic [31:0]        deq_inst;
  logic [31:0]        deq_pc;
  logic [63:0]        deq_order;
  logic [4:0]         iq_count;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .LINE_BYTES (LINE_BYTES),
    .IQ_DEPTH   (IQ_DEPTH),
    .ORDER_W    (ORDER_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_redirect_order (redirect_order),
    .o_ic_addr        (ic_addr),
    .o_ic_rmask       (ic_rmask),
    .i_ic_rline       (ic_rline),
    .i_ic_resp        (ic_resp),
    .o_deq_valid      (deq_valid),
    .i_deq_ready      (deq_ready),
    .o_deq_inst       (deq_inst),
    .o_deq_pc         (deq_pc),
    .o_deq_order      (deq_order),
    .o_iq_count       (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_miss   = 0;
  int          lat      = 0;
  bit          resp_en  = 1'b1;
  bit          force_stale = 1'b0;
  logic [31:0] exp_pc;
  logic [63:0] exp_order;
  logic [3:0]  prev_rmask = 4'h0;
  logic [31:0] prev_addr  = 32'h0;
  logic        prev_resp  = 1'b0;
  logic        prev_rst   = 1'b1;
  logic        prev_redir = 1'b0;

  // Memory image: every word is derived from its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h0000_0013;
  endfunction

  function automatic logic [255:0] build_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word({a[31:5], 5'b0} + 32'(w * 4));
    return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic respond();
    ic_resp = 1'b0;
    if (rst) begin
      lat = 0;
    end else if (force_stale) begin
      ic_resp  = 1'b1;
      ic_rline = {8{32'hDEADBEEF}};
    end else if (resp_en && ic_rmask == 4'hF) begin
      if (lat == 0) lat = int'($urandom_range(1, 4));
      lat--;
      if (lat == 0) begin
        ic_resp  = 1'b1;
        ic_rline = build_line(ic_addr);
      end
    end
  endtask

  // Per-cycle comparison against the sequence model; inputs are stable here.
  task automatic compare();
    if (rst) begin
      chk("rst deq_valid", 64'(deq_valid), 64'(0));
      chk("rst iq_count", 64'(iq_count), 64'(0));
      chk("rst ic_rmask", 64'(ic_rmask), 64'(0));
      chk("rst ic_addr", 64'(ic_addr), 64'(0));
      exp_pc    = RESET_PC;
      exp_order = '0;
    end else begin
      chk("deq_valid rule", 64'(deq_valid), 64'((iq_count != 0) && !redirect_valid));
      chk("iq_count bound", 64'(iq_count > 5'(IQ_DEPTH)), 64'(0));
      if (prev_redir && !prev_rst) chk("flush count", 64'(iq_count), 64'(0));
      if (prev_rmask == 4'hF && !prev_resp && !prev_rst) begin
        chk("miss rmask held", 64'(ic_rmask), 64'(4'hF));
        chk("miss addr held", 64'(ic_addr), 64'(prev_addr));
      end
      if (ic_rmask == 4'hF) begin
        chk("ic_addr aligned", 64'(ic_addr[4:0]), 64'(0));
        if (prev_rmask != 4'hF) n_miss++;
      end
      if (redirect_valid) begin
        exp_pc    = {redirect_pc[31:2], 2'b00};
        exp_order = redirect_order;
      end else if (deq_valid && deq_ready) begin
        chk("deq pc", 64'(deq_pc), 64'(exp_pc));
        chk("deq order", deq_order, exp_order);
        chk("deq inst", 64'(deq_inst), 64'(mem_word(exp_pc)));
        exp_pc    = exp_pc + 32'd4;
        exp_order = exp_order + 64'd1;
      end
    end
    prev_rmask = ic_rmask;
    prev_addr  = ic_addr;
    prev_resp  = ic_resp;
    prev_rst   = rst;
    prev_redir = redirect_valid;
  endtask

  // Inputs change at the falling edge; one call covers one rising edge.
  task automatic step();
    respond();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] pc, input logic [63:0] ord);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    redirect_order = ord;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; redirect_order = '0;
    ic_rline = '0; ic_resp = 1'b0; deq_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Cold start: first miss, one line of 8 entries, then next-line miss.
    for (int i = 0; i < 20 && ic_rmask != 4'hF; i++) step();
    chk("T1 first miss rmask", 64'(ic_rmask), 64'(4'hF));
    chk("T1 first miss addr", 64'(ic_addr), 64'h0000_0000_aaaa_a000);
    for (int i = 0; i < 60 && !(ic_rmask == 4'hF && ic_addr == 32'haaaaa020); i++) step();
    chk("T1 second miss addr", 64'(ic_addr), 64'h0000_0000_aaaa_a020);
    chk("T1 count 8", 64'(iq_count), 64'd8);
    chk("T1 head pc", 64'(deq_pc), 64'h0000_0000_aaaa_a000);
    chk("T1 head order", deq_order, 64'd0);
    chk("T1 head inst", 64'(deq_inst), 64'h0000_0000_aaaa_a013);

    // Saturation, then drain across the pointer wrap.
    for (int i = 0; i < 200 && iq_count != 5'd16; i++) step();
    chk("T2 full", 64'(iq_count), 64'd16);
    repeat (20) step();
    chk("T2 still full", 64'(iq_count), 64'd16);
    chk("T2 head pc held", 64'(deq_pc), 64'h0000_0000_aaaa_a000);
    chk("T2 no request while full", 64'(ic_rmask), 64'd0);
    deq_ready = 1'b1;
    repeat (60) step();

    // Redirect into the resident line while 5 entries are queued.
    deq_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 60 && iq_count != 5'd5; i++) step();
    chk("T3 count 5", 64'(iq_count), 64'd5);
    n0 = n_miss;
    do_redirect(32'haaaaa010, 64'd100);
    for (int i = 0; i < 20 && !deq_valid; i++) step();
    chk("T3 head pc", 64'(deq_pc), 64'h0000_0000_aaaa_a010);
    chk("T3 head order", deq_order, 64'd100);
    chk("T3 head inst", 64'(deq_inst), 64'h0000_0000_aaaa_a003);
    chk("T3 no miss", 64'(n_miss), 64'(n0));

    // Redirect while missing: the request survives, then the new target misses.
    deq_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 30 && !deq_valid; i++) step();
    resp_en = 1'b0;
    for (int i = 0; i < 30 && ic_rmask != 4'hF; i++) step();
    chk("T4 pending addr", 64'(ic_addr), 64'h0000_0000_aaaa_a020);
    do_redirect(32'hbbbb0000, 64'd500);
    repeat (5) step();
    chk("T4 addr kept", 64'(ic_addr), 64'h0000_0000_aaaa_a020);
    chk("T4 rmask kept", 64'(ic_rmask), 64'(4'hF));
    resp_en = 1'b1;
    for (int i = 0; i < 30 && !(ic_rmask == 4'hF && ic_addr == 32'hbbbb0000); i++) step();
    chk("T4 new miss addr", 64'(ic_addr), 64'h0000_0000_bbbb_0000);
    for (int i = 0; i < 30 && !deq_valid; i++) step();
    chk("T4 head pc", 64'(deq_pc), 64'h0000_0000_bbbb_0000);
    chk("T4 head inst", 64'(deq_inst), 64'h0000_0000_bbbb_0013);

    // Reset mid-miss, then a stale response in the first cycle after release.
    resp_en = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && ic_rmask != 4'hF; i++) step();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    force_stale = 1'b1;
    step();
    force_stale = 1'b0;
    chk("T5 fresh rmask", 64'(ic_rmask), 64'(4'hF));
    chk("T5 fresh addr", 64'(ic_addr), 64'h0000_0000_aaaa_a000);
    resp_en = 1'b1;
    for (int i = 0; i < 30 && !deq_valid; i++) step();
    chk("T5 head inst", 64'(deq_inst), 64'h0000_0000_aaaa_a013);

    // PC and order wrap.
    do_redirect(32'hFFFFFFF8, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 60 && !(ic_rmask == 4'hF && ic_addr == 32'h0); i++) step();
    chk("T6 wrap miss rmask", 64'(ic_rmask), 64'(4'hF));
    chk("T6 wrap miss addr", 64'(ic_addr), 64'd0);
    repeat (20) step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      deq_ready = ($urandom % 4) != 0;
      if ($urandom % 40 == 0) begin
        redirect_valid = 1'b1;
        case ($urandom % 3)
          0: redirect_pc = RESET_PC + 32'($urandom % 64) * 32'd4;
          1: redirect_pc = $urandom;
          default: redirect_pc = 32'hFFFFFFE0 + 32'($urandom % 8) * 32'd4;
        endcase
        redirect_order = {$urandom, $urandom};
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    deq_ready = 1'b1;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
